// File: rtl/secuenciador_pkg.sv
// Shared definitions for the shift-register command sequencer.
//   - MODO_* : mode encodings understood by the 4-bit universal shift register.
//   - estado_e : sequencer FSM states.
//   - CNT_W_DEF / RCO_W_DEF : default widths of the cycle count and RCO event counter.
package secuenciador_pkg;

  localparam logic [1:0] MODO_IZQ   = 2'b00;  // shift left
  localparam logic [1:0] MODO_DER   = 2'b01;  // shift right
  localparam logic [1:0] MODO_ROT   = 2'b10;  // rotate
  localparam logic [1:0] MODO_CARGA = 2'b11;  // parallel load

  localparam int unsigned CNT_W_DEF = 4;
  localparam int unsigned RCO_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } estado_e;

endpackage

// File: rtl/secuenciador_registro_contador_ciclos.sv
// contador_ciclos: loadable down-counter holding the remaining ENB cycles of a command.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load value_i (takes priority over dec_i)
//   value_i       : cycle count to load
//   dec_i         : decrement by one (stops at zero)
//   es_uno_o      : remaining count equals 1
module contador_ciclos #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [CNT_W-1:0] value_i,
  input  logic             dec_i,
  output logic             es_uno_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign es_uno_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/secuenciador_registro.sv
// secuenciador_registro: command sequencer that drives ENB/MODO/D of a 4-bit universal
// shift register. A command (mode, data, cycle count) is accepted over CMD_VALID/CMD_READY,
// ENB is held high for exactly the commanded number of clocks, then DONE pulses for one
// cycle and Q_LAST captures the register's Q at the end of that cycle. RCO_CNT counts
// (saturating) the RCO-high cycles seen while the command was active.
// Ports:
//   CLK, RST_N                       : clock, asynchronous active-low reset
//   ABORT                            : early termination (only with SECUENCIADOR_ABORT_EN)
//   CMD_VALID/CMD_READY              : command handshake
//   CMD_MODO, CMD_D, CMD_CNT         : command mode, parallel data, ENB cycle count
//   ENB, MODO, D                     : shift-register controls
//   Q, RCO                           : shift-register outputs
//   DONE, Q_LAST, RCO_CNT            : completion report
// Optional feature: define SECUENCIADOR_ABORT_EN to add the ABORT input.
module secuenciador_registro
  import secuenciador_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned RCO_W = RCO_W_DEF
) (
  input  logic             CLK,
  input  logic             RST_N,
`ifdef SECUENCIADOR_ABORT_EN
  input  logic             ABORT,
`endif
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_MODO,
  input  logic [3:0]       CMD_D,
  input  logic [CNT_W-1:0] CMD_CNT,
  output logic             ENB,
  output logic [1:0]       MODO,
  output logic [3:0]       D,
  input  logic [3:0]       Q,
  input  logic             RCO,
  output logic             DONE,
  output logic [3:0]       Q_LAST,
  output logic [RCO_W-1:0] RCO_CNT
);

  estado_e          state_d, state_q;
  logic             cmd_ready_d, cmd_ready_q;
  logic             enb_d, enb_q;
  logic [1:0]       modo_d, modo_q;
  logic [3:0]       d_d, d_q;
  logic             done_d, done_q;
  logic [3:0]       q_last_d, q_last_q;
  logic [RCO_W-1:0] rco_cnt_d, rco_cnt_q;

  logic cnt_load, cnt_dec, cnt_es_uno;
  logic abort;
  logic aceptar;

`ifdef SECUENCIADOR_ABORT_EN
  assign abort = ABORT;
`else
  assign abort = 1'b0;
`endif

  // cmd_ready_q is only ever set while idle, so it alone qualifies the handshake.
  assign aceptar = CMD_VALID & cmd_ready_q;

  contador_ciclos #(
    .CNT_W (CNT_W)
  ) u_contador_ciclos (
    .clk_i    (CLK),
    .rst_ni   (RST_N),
    .load_i   (cnt_load),
    .value_i  (CMD_CNT),
    .dec_i    (cnt_dec),
    .es_uno_o (cnt_es_uno)
  );

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    enb_d       = enb_q;
    modo_d      = modo_q;
    d_d         = d_q;
    done_d      = 1'b0;
    q_last_d    = q_last_q;
    rco_cnt_d   = rco_cnt_q;
    cnt_load    = 1'b0;
    cnt_dec     = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Ready rises one edge after reset release and after each completion.
        cmd_ready_d = 1'b1;
        enb_d       = 1'b0;
        if (aceptar) begin
          modo_d      = CMD_MODO;
          d_d         = CMD_D;
          rco_cnt_d   = '0;
          cnt_load    = 1'b1;
          cmd_ready_d = 1'b0;
          if (CMD_CNT != '0) begin
            state_d = RUN;
            enb_d   = 1'b1;
          end else begin
            state_d = FIN;
            done_d  = 1'b1;
          end
        end
      end
      RUN: begin
        cnt_dec = 1'b1;
        if (cnt_es_uno || abort) begin
          state_d = FIN;
          enb_d   = 1'b0;
          done_d  = 1'b1;
        end
      end
      FIN: begin
        // Q here reflects the register after its last enabled edge.
        q_last_d    = Q;
        state_d     = IDLE;
        cmd_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        enb_d       = 1'b0;
        cmd_ready_d = 1'b0;
      end
    endcase

    if ((state_q == RUN || state_q == FIN) && RCO && (rco_cnt_q != '1)) begin
      rco_cnt_d = rco_cnt_q + RCO_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      enb_q       <= 1'b0;
      modo_q      <= MODO_IZQ;
      d_q         <= '0;
      done_q      <= 1'b0;
      q_last_q    <= '0;
      rco_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      enb_q       <= enb_d;
      modo_q      <= modo_d;
      d_q         <= d_d;
      done_q      <= done_d;
      q_last_q    <= q_last_d;
      rco_cnt_q   <= rco_cnt_d;
    end
  end

  assign CMD_READY = cmd_ready_q;
  assign ENB       = enb_q;
  assign MODO      = modo_q;
  assign D         = d_q;
  assign DONE      = done_q;
  assign Q_LAST    = q_last_q;
  assign RCO_CNT   = rco_cnt_q;

endmodule

// File: tb/tb_secuenciador_registro.sv
// Bench for secuenciador_registro: a behavioural 4-bit shift register plant closes the loop,
// RCO is driven randomly, and every command is checked cycle by cycle against timing and
// results derived from the command itself. RCO_W is shrunk to 3 so saturation is reachable.
module tb_secuenciador_registro;
  import secuenciador_pkg::*;

  localparam int unsigned CNT_W = 4;
  localparam int unsigned RCO_W = 3;
  localparam int          RCO_MAX = (1 << RCO_W) - 1;

  logic             CLK = 1'b0;
  logic             RST_N = 1'b1;
  logic             CMD_VALID = 1'b0;
  logic             CMD_READY;
  logic [1:0]       CMD_MODO = '0;
  logic [3:0]       CMD_D = '0;
  logic [CNT_W-1:0] CMD_CNT = '0;
  logic             ENB;
  logic [1:0]       MODO;
  logic [3:0]       D;
  logic [3:0]       Q;
  logic             RCO = 1'b0;
  logic             DONE;
  logic [3:0]       Q_LAST;
  logic [RCO_W-1:0] RCO_CNT;
`ifdef SECUENCIADOR_ABORT_EN
  logic             ABORT = 1'b0;
`endif

  int   n_checks = 0;
  int   n_pass = 0;
  logic [3:0] q_ref = '0;
  bit   rco_en = 1'b1;

  always #5 CLK = ~CLK;

  secuenciador_registro #(
    .CNT_W (CNT_W),
    .RCO_W (RCO_W)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
`ifdef SECUENCIADOR_ABORT_EN
    .ABORT     (ABORT),
`endif
    .CMD_VALID (CMD_VALID),
    .CMD_READY (CMD_READY),
    .CMD_MODO  (CMD_MODO),
    .CMD_D     (CMD_D),
    .CMD_CNT   (CMD_CNT),
    .ENB       (ENB),
    .MODO      (MODO),
    .D         (D),
    .Q         (Q),
    .RCO       (RCO),
    .DONE      (DONE),
    .Q_LAST    (Q_LAST),
    .RCO_CNT   (RCO_CNT)
  );

  // Stand-in for the universal shift register, sharing the sequencer's reset.
  logic [3:0] plant_q;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      plant_q <= '0;
    end else if (ENB) begin
      case (MODO)
        MODO_IZQ: plant_q <= {plant_q[2:0], 1'b0};
        MODO_DER: plant_q <= {1'b0, plant_q[3:1]};
        MODO_ROT: plant_q <= {plant_q[2:0], plant_q[3]};
        default:  plant_q <= D;
      endcase
    end
  end
  assign Q = plant_q;

  // Register effect of one enabled edge, in plain arithmetic.
  function automatic logic [3:0] apply_op(input logic [3:0] q, input logic [1:0] m,
                                          input logic [3:0] d);
    int v;
    v = int'(q);
    case (m)
      2'b00:   v = (v * 2) % 16;
      2'b01:   v = v / 2;
      2'b10:   v = (v * 2) % 16 + v / 8;
      default: v = int'(d);
    endcase
    return v[3:0];
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_ready"}, 32'(CMD_READY), 32'd0);
    check_eq({tag, "_enb"}, 32'(ENB), 32'd0);
    check_eq({tag, "_modo"}, 32'(MODO), 32'd0);
    check_eq({tag, "_d"}, 32'(D), 32'd0);
    check_eq({tag, "_done"}, 32'(DONE), 32'd0);
    check_eq({tag, "_qlast"}, 32'(Q_LAST), 32'd0);
    check_eq({tag, "_rcocnt"}, 32'(RCO_CNT), 32'd0);
  endtask

  // Called at a negedge. Issues one command, checks it to completion, returns at the
  // negedge of the first cycle CMD_READY is high again. With hold set, CMD_VALID stays
  // high carrying the next command while this one runs.
  task automatic run_cmd(input logic [1:0] modo, input logic [3:0] d, input int n,
                         input int abort_at, input bit hold, input logic [1:0] nmodo,
                         input logic [3:0] nd, input int nn);
    int waited;
    int n_eff;
    int rco_ref;
    logic [3:0] q_exp;
    CMD_VALID = 1'b1;
    CMD_MODO  = modo;
    CMD_D     = d;
    CMD_CNT   = CNT_W'(n);
    waited = 0;
    while (CMD_READY !== 1'b1 && waited < 64) begin
      @(negedge CLK);
      waited++;
    end
    if (CMD_READY !== 1'b1) begin
      check_eq("ready_timeout", 32'(CMD_READY), 32'd1);
      CMD_VALID = 1'b0;
      return;
    end
    n_eff = (abort_at > 0 && abort_at < n) ? abort_at : n;
    q_exp = q_ref;
    for (int i = 0; i < n_eff; i++) q_exp = apply_op(q_exp, modo, d);

    @(posedge CLK);
    #1;
    if (hold) begin
      CMD_MODO = nmodo;
      CMD_D    = nd;
      CMD_CNT  = CNT_W'(nn);
    end else begin
      CMD_VALID = 1'b0;
      CMD_MODO  = 2'($urandom);
      CMD_D     = 4'($urandom);
      CMD_CNT   = CNT_W'($urandom);
    end

    rco_ref = 0;
    for (int k = 1; k <= n_eff + 2; k++) begin
      @(negedge CLK);
      check_eq("enb", 32'(ENB), 32'(k <= n_eff));
      check_eq("done", 32'(DONE), 32'(k == n_eff + 1));
      check_eq("ready", 32'(CMD_READY), 32'(k == n_eff + 2));
      check_eq("modo", 32'(MODO), 32'(modo));
      check_eq("d", 32'(D), 32'(d));
      if (k == n_eff + 2) begin
        check_eq("q_last", 32'(Q_LAST), 32'(q_exp));
        check_eq("rco_cnt", 32'(RCO_CNT), 32'(rco_ref > RCO_MAX ? RCO_MAX : rco_ref));
      end
`ifdef SECUENCIADOR_ABORT_EN
      // Abort pulses in FIN must be ignored.
      ABORT = (k == abort_at) || (k == n_eff + 1 && $urandom_range(0, 1) == 1);
`endif
      RCO = rco_en ? 1'($urandom) : 1'b0;
      if (k <= n_eff + 1 && RCO) rco_ref++;
    end
    q_ref = q_exp;
  endtask

  task automatic reset_mid_run();
    CMD_VALID = 1'b1;
    CMD_MODO  = MODO_ROT;
    CMD_D     = 4'h3;
    CMD_CNT   = CNT_W'(5);
    @(posedge CLK);
    #1;
    CMD_VALID = 1'b0;
    @(negedge CLK);
    check_eq("rst_mid_enb1", 32'(ENB), 32'd1);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check_reset_vals("rst_mid");
    repeat (2) begin
      @(negedge CLK);
      check_eq("rst_mid_done", 32'(DONE), 32'd0);
    end
    RST_N = 1'b1;
    #1;
    check_eq("rst_rel_ready0", 32'(CMD_READY), 32'd0);
    @(negedge CLK);
    check_eq("rst_rel_ready1", 32'(CMD_READY), 32'd1);
    check_eq("rst_rel_done", 32'(DONE), 32'd0);
    q_ref = '0;
  endtask

  initial begin
    logic [1:0] c_modo, x_modo;
    logic [3:0] c_d, x_d;
    int         c_n, x_n, c_ab;
    bit         c_hold;

    #1 RST_N = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check_reset_vals("rst");
    end
    RST_N = 1'b1;
    #1;
    check_eq("rel_ready0", 32'(CMD_READY), 32'd0);
    @(negedge CLK);
    check_eq("rel_ready1", 32'(CMD_READY), 32'd1);

    // Parallel load of 1010 for one cycle.
    run_cmd(MODO_CARGA, 4'b1010, 1, 0, 1'b0, 2'b00, 4'h0, 0);
    // Load 0001 then shift left three times -> 1000.
    run_cmd(MODO_CARGA, 4'b0001, 1, 0, 1'b0, 2'b00, 4'h0, 0);
    run_cmd(MODO_IZQ, 4'h0, 3, 0, 1'b0, 2'b00, 4'h0, 0);
    // Zero count with RCO quiet.
    rco_en = 1'b0;
    run_cmd(MODO_DER, 4'h5, 0, 0, 1'b0, 2'b00, 4'h0, 0);
    rco_en = 1'b1;
    // Back-to-back with CMD_VALID held high throughout.
    run_cmd(MODO_CARGA, 4'b0110, 2, 0, 1'b1, MODO_ROT, 4'h9, 3);
    run_cmd(MODO_ROT, 4'h9, 3, 0, 1'b0, 2'b00, 4'h0, 0);
    // Long command so the saturating counter is exercised.
    run_cmd(MODO_ROT, 4'h0, 15, 0, 1'b0, 2'b00, 4'h0, 0);
`ifdef SECUENCIADOR_ABORT_EN
    run_cmd(MODO_DER, 4'h0, 5, 2, 1'b0, 2'b00, 4'h0, 0);
`endif
    reset_mid_run();

    c_modo = 2'($urandom);
    c_d    = 4'($urandom);
    c_n    = $urandom_range(0, 15);
    for (int i = 0; i < 30; i++) begin
      x_modo = 2'($urandom);
      x_d    = 4'($urandom);
      x_n    = $urandom_range(0, 15);
      c_hold = ($urandom_range(0, 2) == 0);
      c_ab   = 0;
`ifdef SECUENCIADOR_ABORT_EN
      if (c_n > 1 && $urandom_range(0, 2) == 0) c_ab = $urandom_range(1, c_n - 1);
`endif
      run_cmd(c_modo, c_d, c_n, c_ab, c_hold, x_modo, x_d, x_n);
      if (!c_hold) repeat ($urandom_range(0, 2)) @(negedge CLK);
      c_modo = x_modo;
      c_d    = x_d;
      c_n    = x_n;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/secuenciador_registro.md
# secuenciador_registro

Command sequencer directly upstream of the 4-bit universal shift register; it generates that register's ENB, MODO and D inputs. It accepts a command (mode, data, cycle count) over a valid/ready handshake and holds ENB high for exactly that many clocks. It returns the register's Q and RCO as a completion report.

## Interface
- CNT_W, default 4: width of the command cycle count.
- RCO_W, default 8: width of the saturating RCO event counter.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- CMD_VALID  input  1  a command is present.
- CMD_READY  output  1  sequencer can accept a command.
- CMD_MODO  input  2  mode to apply.
- CMD_D  input  4  parallel data to apply.
- CMD_CNT  input  CNT_W  number of ENB-active cycles.
- ENB  output  1  register enable.
- MODO  output  2  register mode.
- D  output  4  register parallel data.
- Q  input  4  register output.
- RCO  input  1  register ripple carry out.
- DONE  output  1  one-cycle completion pulse.
- Q_LAST  output  4  Q captured at completion.
- RCO_CNT  output  RCO_W  RCO-high cycles seen during the last command.

## Operation
- Mode encoding to the register:
  - 00 shift left.
  - 01 shift right.
  - 10 rotate.
  - 11 parallel load.
- MODO is passed through unmodified.
- States:
  - IDLE: CMD_READY=1, ENB=0. On CMD_VALID&CMD_READY, latch CMD_MODO, CMD_D and CMD_CNT, and clear RCO_CNT. Go to RUN if CMD_CNT≠0; go to FIN if CMD_CNT=0.
  - RUN: ENB=1; MODO and D equal the latched values. Decrement the remaining count each cycle. Go to FIN when the remaining count is 1.
  - FIN: ENB=0, DONE=1. Q_LAST<=Q at the end of the cycle. Return to IDLE.
- RCO_CNT increments on every cycle with RCO=1 while in RUN or FIN. It saturates at 2^RCO_W−1 and holds its value in IDLE.
- CMD_D, CMD_MODO and CMD_CNT are don't-care when CMD_VALID=0 or CMD_READY=0.
- CMD_VALID held high while CMD_READY=0 is legal. The command waits and is accepted on the first IDLE cycle.
- MODO and D keep their last command's values after ENB drops; they change only on the next accept.
- Every output is registered.

## Timing
- Reset values: CMD_READY=0, ENB=0, MODO=00, D=0000, DONE=0, Q_LAST=0000, RCO_CNT=0. State is IDLE.
- CMD_READY becomes 1 at the first rising edge after RST_N deasserts.
- Command accepted at edge t with CMD_CNT=N>0:
  - ENB=1 during cycles t+1 through t+N.
  - DONE=1 during cycle t+N+1.
  - CMD_READY=1 again from cycle t+N+2.
- Throughput is one command per N+2 cycles.
- Command with N=0: DONE during cycle t+1 and no ENB. Q_LAST captures the unchanged Q.
- Q_LAST reflects the register state after its N-th enabled edge.
- RST_N asserted mid-command forces all outputs to their reset values immediately. The command is discarded with no DONE.

## Configuration
- SECUENCIADOR_ABORT_EN defined: adds input ABORT (1 bit).
  - ABORT=1 during a RUN cycle forces FIN on the next edge. ENB is 0 from that cycle, then DONE, Q_LAST and RCO_CNT behave as for normal completion.
  - ABORT is ignored in IDLE and FIN.
- SECUENCIADOR_ABORT_EN undefined: the port does not exist and commands always run the full count.

## Structure
- Package secuenciador_pkg holds:
  - MODO constants MODO_IZQ=2'b00, MODO_DER=2'b01, MODO_ROT=2'b10, MODO_CARGA=2'b11.
  - State enum IDLE/RUN/FIN.
  - Default widths CNT_W and RCO_W.
- One sub-module, contador_ciclos:
  - Loadable down-counter of CNT_W bits.
  - Inputs: load, value, decrement.
  - Output: flag for "remaining count equals 1".
- FSM, RCO counter and output registers live in secuenciador_registro.

## Test plan
- Reset: RST_N=0 for 3 cycles, then released → all outputs at reset values; CMD_READY=1 one edge after release.
- Load: CMD_MODO=11, CMD_D=1010, CMD_CNT=1 → ENB high for exactly 1 cycle with MODO=11, D=1010; DONE next cycle; Q_LAST=1010 against the real register.
- Shift: CMD_MODO=00, CMD_CNT=3 after loading 0001 → ENB high for 3 cycles; Q_LAST=1000; DONE 4 cycles after accept; CMD_READY back 5 cycles after accept.
- Zero count: CMD_CNT=0 → no ENB pulse, DONE in cycle after accept, RCO_CNT=0.
- Back-to-back: CMD_VALID held high with two commands queued by the bench → second accepted on the first IDLE cycle after DONE; no overlap of ENB windows.
- Reset mid-RUN, and ABORT when SECUENCIADOR_ABORT_EN is defined:
  - RST_N low during cycle 2 of a 5-cycle command → ENB=0 immediately, no DONE.
  - ABORT in cycle 2 → ENB high for exactly 2 cycles, then DONE.
